// File: rtl/pipe_pkg.sv
// Shared definitions for the CPU pipeline-stage buffers.
package pipe_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  // RV32I canonical NOP (addi x0, x0, 0), handy as a BUBBLE_VAL override
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pipe_stage_buf_sat_counter.sv
// Saturating accumulator: adds add_i when en_i is high and sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 16,
  parameter int ADD_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [ADD_W-1:0] add_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q;

  // One spare bit holds the carry; any carry means the true sum exceeds CNT_MAX
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [ADD_W-1:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + (CNT_W+1)'(b);
    return sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
  endfunction

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= sat_add(cnt_q, add_i);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic two-entry pipeline-stage register with flush/stall and a registered
// upstream ready, plus a saturating count of entries squashed by flush.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int                DATA_W     = 96,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}},
  parameter int                CNT_W      = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occ_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  logic [1:0]        state_q, state_d;
  logic              in_ready_q;
  logic [DATA_W-1:0] main_q, skid_q;
  logic              main_we, main_from_skid, skid_we;
  logic              acc, deq;
  logic [1:0]        flush_add;

  assign out_valid_o = (state_q != ST_EMPTY);
  assign occ_o       = state_q;
  assign in_ready_o  = in_ready_q;
  assign out_data_o  = out_valid_o ? main_q : BUBBLE_VAL;

  assign acc = in_valid_i & in_ready_q & ~flush_i;
  assign deq = out_valid_o & out_ready_i & ~stall_i & ~flush_i;

  always_comb begin
    state_d        = state_q;
    main_we        = 1'b0;
    main_from_skid = 1'b0;
    skid_we        = 1'b0;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            state_d = ST_ONE;
            main_we = 1'b1;
          end
        end
        ST_ONE: begin
          if (acc && deq) begin
            main_we = 1'b1;
          end else if (deq) begin
            state_d = ST_EMPTY;
          end else if (acc) begin
            skid_we = 1'b1;
            state_d = ST_TWO;
          end
        end
        ST_TWO: begin
          // in_ready_q is low here, so only a dequeue can happen
          if (deq) begin
            main_we        = 1'b1;
            main_from_skid = 1'b1;
            state_d        = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // ---- registered control ----
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_TWO);
    end
  end

  // ---- payload registers (unreset, hidden behind out_valid_o) ----
  always_ff @(posedge clk_i) begin
    if (main_we) main_q <= main_from_skid ? skid_q : in_data_i;
    if (skid_we) skid_q <= in_data_i;
  end

  // Held entries plus an entry being accepted this cycle are all squashed
  assign flush_add = state_q + {1'b0, in_valid_i & in_ready_q};

  sat_counter #(
    .CNT_W (CNT_W),
    .ADD_W (2)
  ) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (flush_i),
    .add_i (flush_add),
    .cnt_o (flush_cnt_o)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: vector table, hand sequences and a random run against a queue model.
module tb_pipe_stage_buf;
  import pipe_pkg::*;

  localparam int DW = 32;

  logic          clk;
  logic          rst_i;
  logic          flush, stall, in_valid, out_ready;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid, in_ready2, out_valid2;
  logic [DW-1:0] out_data, out_data2;
  logic [1:0]    occ, occ2;
  logic [15:0]   cnt;
  logic [1:0]    cnt2;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] q[$];
  bit            rdy_m;
  int            cnt_m;

  pipe_stage_buf #(.DATA_W(DW), .BUBBLE_VAL(NOP_INSTR), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush), .stall_i(stall),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .occ_o(occ), .flush_cnt_o(cnt));

  pipe_stage_buf #(.DATA_W(DW), .CNT_W(2)) dut2 (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush), .stall_i(stall),
    .in_valid_i(in_valid), .in_ready_o(in_ready2), .in_data_i(in_data),
    .out_valid_o(out_valid2), .out_ready_i(out_ready), .out_data_o(out_data2),
    .occ_o(occ2), .flush_cnt_o(cnt2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    rdy_m = 1'b1;
    cnt_m = 0;
  endtask

  task automatic model_step();
    bit acc, deq;
    acc = in_valid && rdy_m && !flush;
    deq = (q.size() > 0) && out_ready && !stall && !flush;
    if (flush) begin
      cnt_m += q.size() + ((in_valid && rdy_m) ? 1 : 0);
      q.delete();
    end else begin
      if (deq) void'(q.pop_front());
      if (acc) q.push_back(in_data);
    end
    rdy_m = (q.size() < 2);
  endtask

  task automatic check_model();
    logic [31:0] exp_data;
    exp_data = (q.size() > 0) ? q[0] : NOP_INSTR;
    chk("m_out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("m_out_data", out_data, exp_data);
    chk("m_in_ready", 32'(in_ready), 32'(rdy_m));
    chk("m_occ", 32'(occ), 32'(q.size()));
    chk("m_flush_cnt", 32'(cnt), (cnt_m > 65535) ? 32'd65535 : 32'(cnt_m));
    chk("m_flush_cnt_sat2", 32'(cnt2), (cnt_m > 3) ? 32'd3 : 32'(cnt_m));
  endtask

  // Called just after a falling edge; leaves the bench just after the next one.
  task automatic cyc(input logic v, input logic [31:0] d, input logic ord,
                     input logic st, input logic fl);
    in_valid  = v;
    in_data   = d;
    out_ready = ord;
    stall     = st;
    flush     = fl;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        ord, st, fl;
    logic        ev;
    logic [31:0] ed;
    logic        er;
    logic [1:0]  eo;
    logic [15:0] ec;
  } vec_t;

  vec_t tbl[15];

  initial begin
    tbl[0]  = '{1'b1, 32'd5,  1'b0, 1'b0, 1'b0, 1'b1, 32'd5,   1'b1, 2'd1, 16'd0};
    tbl[1]  = '{1'b1, 32'd6,  1'b0, 1'b0, 1'b0, 1'b1, 32'd5,   1'b0, 2'd2, 16'd0};
    tbl[2]  = '{1'b1, 32'd7,  1'b0, 1'b0, 1'b0, 1'b1, 32'd5,   1'b0, 2'd2, 16'd0};
    tbl[3]  = '{1'b1, 32'd7,  1'b1, 1'b0, 1'b0, 1'b1, 32'd6,   1'b1, 2'd1, 16'd0};
    tbl[4]  = '{1'b1, 32'd7,  1'b1, 1'b0, 1'b0, 1'b1, 32'd7,   1'b1, 2'd1, 16'd0};
    tbl[5]  = '{1'b0, 32'd0,  1'b1, 1'b0, 1'b0, 1'b0, NOP_INSTR, 1'b1, 2'd0, 16'd0};
    tbl[6]  = '{1'b1, 32'd9,  1'b1, 1'b0, 1'b0, 1'b1, 32'd9,   1'b1, 2'd1, 16'd0};
    tbl[7]  = '{1'b0, 32'd0,  1'b1, 1'b1, 1'b0, 1'b1, 32'd9,   1'b1, 2'd1, 16'd0};
    tbl[8]  = '{1'b1, 32'd10, 1'b1, 1'b1, 1'b0, 1'b1, 32'd9,   1'b0, 2'd2, 16'd0};
    tbl[9]  = '{1'b0, 32'd0,  1'b1, 1'b1, 1'b0, 1'b1, 32'd9,   1'b0, 2'd2, 16'd0};
    tbl[10] = '{1'b0, 32'd0,  1'b1, 1'b0, 1'b0, 1'b1, 32'd10,  1'b1, 2'd1, 16'd0};
    tbl[11] = '{1'b1, 32'd11, 1'b1, 1'b1, 1'b1, 1'b0, NOP_INSTR, 1'b1, 2'd0, 16'd2};
    tbl[12] = '{1'b1, 32'd12, 1'b0, 1'b0, 1'b0, 1'b1, 32'd12,  1'b1, 2'd1, 16'd2};
    tbl[13] = '{1'b1, 32'd13, 1'b0, 1'b0, 1'b0, 1'b1, 32'd12,  1'b0, 2'd2, 16'd2};
    tbl[14] = '{1'b1, 32'd14, 1'b0, 1'b0, 1'b1, 1'b0, NOP_INSTR, 1'b1, 2'd0, 16'd4};

    rst_i = 1'b0; flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
    out_ready = 1'b0; in_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_model();
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_data", out_data, NOP_INSTR);
    rst_i = 1'b1;

    // Directed table: backpressure, FIFO order, stall, flush over stall, flush counting
    for (int i = 0; i < 15; i++) begin
      cyc(tbl[i].v, tbl[i].d, tbl[i].ord, tbl[i].st, tbl[i].fl);
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_data", i), out_data, tbl[i].ed);
      chk($sformatf("tbl%0d_ready", i), 32'(in_ready), 32'(tbl[i].er));
      chk($sformatf("tbl%0d_occ", i), 32'(occ), 32'(tbl[i].eo));
      chk($sformatf("tbl%0d_cnt", i), 32'(cnt), 32'(tbl[i].ec));
    end
    chk("sat2_after_table", 32'(cnt2), 32'd3);

    // Full-rate stream 1..8
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 32'(i), 1'b1, 1'b0, 1'b0);
      chk($sformatf("stream%0d_data", i), out_data, 32'(i));
      chk($sformatf("stream%0d_ready", i), 32'(in_ready), 32'd1);
      chk($sformatf("stream%0d_occ", i), 32'(occ), 32'd1);
    end
    cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("stream_drain_valid", 32'(out_valid), 32'd0);

    // Asynchronous reset while full, then first push after release
    cyc(1'b1, 32'hA1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'hA2, 1'b0, 1'b0, 1'b0);
    chk("pre_reset_occ", 32'(occ), 32'd2);
    in_valid = 1'b0;
    #2 rst_i = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_data", out_data, NOP_INSTR);
    chk("async_rst_ready", 32'(in_ready), 32'd1);
    chk("async_rst_occ", 32'(occ), 32'd0);
    chk("async_rst_cnt", 32'(cnt), 32'd0);
    chk("async_rst_cnt2", 32'(cnt2), 32'd0);
    @(negedge clk);
    rst_i = 1'b1;
    model_reset();
    cyc(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
    chk("post_reset_data", out_data, 32'hA);
    chk("post_reset_valid", 32'(out_valid), 32'd1);

    // Random traffic against the queue model
    for (int n = 0; n < 600; n++) begin
      cyc($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
          $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
